// File: rtl/c432_key_loader.sv
// c432_key_loader
//   Serial key loader for the logic-locked c432 core. Key bits arrive LSB
//   first on key_sdi/key_valid, collect in a shadow register, and reach
//   key_out only when the full load has been committed. Once committed,
//   the key stays locked until rst.
//
//   Optional feature: define C432_KEY_PARITY_EN to require one trailing
//   even-parity bit. A failed check pulses key_err and discards the load.
//
// Ports
//   clk         single clock, rising edge
//   rst         synchronous active-high reset
//   key_start   begin or restart a key load
//   key_sdi     serial key bit, s_0 first
//   key_valid   key_sdi holds a valid bit
//   key_ready   loader accepts a bit this cycle
//   key_out     committed key, bit i drives s_i of the core
//   key_locked  key committed, sticky until rst
//   key_done    one-cycle pulse on commit
//   key_err     one-cycle pulse on a rejected load (0 without parity)

module c432_key_loader #(
  parameter int KEY_W = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             key_start,
  input  logic             key_sdi,
  input  logic             key_valid,
  output logic             key_ready,
  output logic [KEY_W-1:0] key_out,
  output logic             key_locked,
  output logic             key_done,
  output logic             key_err
);

  // Wide enough to hold KEY_W itself, so the count never wraps.
  localparam int CNT_W = $clog2(KEY_W + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(KEY_W - 1);

  typedef enum logic [2:0] {
    IDLE,
    SHIFT,
    CHK,
    COMMIT,
    LOCKED
  } state_t;

  state_t           state_reg;
  logic [CNT_W-1:0] bit_cnt_reg;
  logic [KEY_W-1:0] shadow_reg;
  logic [KEY_W-1:0] key_out_reg;
  logic             key_locked_reg;
  logic             key_done_reg;
  logic [KEY_W-1:0] shadow_we;
  logic             shift_accept;
  logic             last_bit;

  // key_start wins over a bit presented in the same cycle.
  assign shift_accept = (state_reg == SHIFT) && key_valid && !key_start;
  assign last_bit     = (bit_cnt_reg == LAST_IDX);

  // One-hot write enable: the n-th accepted bit lands in shadow bit n.
  genvar gi;
  generate
    for (gi = 0; gi < KEY_W; gi++) begin : g_shadow_we
      assign shadow_we[gi] = shift_accept && (bit_cnt_reg == CNT_W'(gi));
    end
  endgenerate

`ifdef C432_KEY_PARITY_EN
  logic key_err_reg;
  assign key_ready = (state_reg == SHIFT) || (state_reg == CHK);
  assign key_err   = key_err_reg;
`else
  assign key_ready = (state_reg == SHIFT);
  assign key_err   = 1'b0;
`endif

  assign key_out    = key_out_reg;
  assign key_locked = key_locked_reg;
  assign key_done   = key_done_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      bit_cnt_reg    <= '0;
      shadow_reg     <= '0;
      key_out_reg    <= '0;
      key_locked_reg <= 1'b0;
      key_done_reg   <= 1'b0;
`ifdef C432_KEY_PARITY_EN
      key_err_reg    <= 1'b0;
`endif
    end else begin
      key_done_reg <= 1'b0;
`ifdef C432_KEY_PARITY_EN
      key_err_reg  <= 1'b0;
`endif
      case (state_reg)
        IDLE: begin
          // key_valid alone is ignored here; only key_start opens a load.
          if (key_start) begin
            shadow_reg  <= '0;
            bit_cnt_reg <= '0;
            state_reg   <= SHIFT;
          end
        end

        SHIFT: begin
          if (key_start) begin
            shadow_reg  <= '0;
            bit_cnt_reg <= '0;
          end else if (key_valid) begin
            shadow_reg  <= (shadow_reg & ~shadow_we) |
                           (shadow_we & {KEY_W{key_sdi}});
            bit_cnt_reg <= bit_cnt_reg + 1'b1;
            if (last_bit) begin
`ifdef C432_KEY_PARITY_EN
              state_reg <= CHK;
`else
              state_reg <= COMMIT;
`endif
            end
          end
        end

`ifdef C432_KEY_PARITY_EN
        CHK: begin
          if (key_start) begin
            shadow_reg  <= '0;
            bit_cnt_reg <= '0;
            state_reg   <= SHIFT;
          end else if (key_valid) begin
            // Even parity: key bits plus the parity bit must XOR to 0.
            if ((^shadow_reg) ^ key_sdi) begin
              key_err_reg <= 1'b1;
              shadow_reg  <= '0;
              bit_cnt_reg <= '0;
              state_reg   <= IDLE;
            end else begin
              state_reg <= COMMIT;
            end
          end
        end
`else
        CHK: begin
          state_reg <= IDLE;
        end
`endif

        COMMIT: begin
          // key_start is deliberately not looked at: the commit completes.
          key_out_reg    <= shadow_reg;
          key_locked_reg <= 1'b1;
          key_done_reg   <= 1'b1;
          state_reg      <= LOCKED;
        end

        LOCKED: begin
          state_reg <= LOCKED;
        end

        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule
